// File: rtl/einstein_clk_rst_gen.sv
// ----------------------------------------------------------------------------
// einstein_clk_rst_gen
//
// Purpose:
//   Reset sequencer and clock-enable generator for the Einstein core, running
//   in the 32 MHz clk_sys domain directly behind the system PLL. It
//   synchronises the PLL lock flag and produces a stretched system reset.
//   Once out of reset it produces single-cycle strobes for the Z80 (rising
//   and falling phase, with a turbo option), the WD1770 FDC and the AY PSG.
//   Every core block runs on clk_sys qualified by these strobes.
//
// Ports:
//   clk_sys     in   32 MHz system clock
//   reset_n     in   global reset, asynchronous assert, active-low
//   pll_locked  in   PLL lock flag, asynchronous to clk_sys
//   soft_reset  in   synchronous level reset request, active-high
//   turbo       in   synchronous; 1 selects the CPU_DIV/2 CPU strobe rate
//   sys_reset   out  active-high core reset (state != RUN)
//   sys_reset_n out  exact inverse of sys_reset
//   ce_cpu      out  CPU rising-phase strobe
//   ce_cpu_n    out  CPU falling-phase strobe, half a CPU period after ce_cpu
//   ce_fdc      out  FDC strobe, every FDC_DIV cycles
//   ce_psg      out  PSG strobe, every PSG_DIV cycles
//   state       out  debug: 00 HOLD, 01 STRETCH, 10 RUN
// ----------------------------------------------------------------------------
module einstein_clk_rst_gen #(
    parameter int STRETCH_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2,
    parameter int CPU_DIV        = 8,
    parameter int FDC_DIV        = 4,
    parameter int PSG_DIV        = 16
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    input  logic       turbo,
    output logic       sys_reset,
    output logic       sys_reset_n,
    output logic       ce_cpu,
    output logic       ce_cpu_n,
    output logic       ce_fdc,
    output logic       ce_psg,
    output logic [1:0] state
);

    localparam int STRETCH_W = $clog2(STRETCH_CYCLES);
    localparam int PHASE_W   = $clog2(PSG_DIV);

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0]   PHASE_LAST   = PHASE_W'(PSG_DIV - 1);
    localparam logic [PHASE_W-1:0]   CPU_MASK_NRM = PHASE_W'(CPU_DIV - 1);
    localparam logic [PHASE_W-1:0]   CPU_MASK_TRB = PHASE_W'(CPU_DIV / 2 - 1);
    localparam logic [PHASE_W-1:0]   FDC_MASK     = PHASE_W'(FDC_DIV - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_STRETCH = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [STRETCH_W-1:0]   r_stretch;
    logic [PHASE_W-1:0]     r_phase;
    logic                   r_turbo_q;

    logic                   w_locked_s;
    logic                   w_abort;
    logic                   w_run_stay;
    logic                   w_run;
    logic [PHASE_W-1:0]     w_cpu_mask;
    logic [PHASE_W-1:0]     w_cpu_phase;

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Loss of lock or a soft reset request overrides every transition.
    assign w_abort    = !w_locked_s || soft_reset;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_HOLD;
        else
            r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD:    w_state_next = ST_STRETCH;
                ST_STRETCH: if (r_stretch == STRETCH_LAST) w_state_next = ST_RUN;
                ST_RUN:     w_state_next = ST_RUN;
                default:    w_state_next = ST_HOLD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stretch counter: counts only while in STRETCH, so every entry into
    // STRETCH starts from zero and always yields the full stretch length.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_stretch <= '0;
        else if (w_abort || (r_state != ST_STRETCH) || (r_stretch == STRETCH_LAST))
            r_stretch <= '0;
        else
            r_stretch <= r_stretch + STRETCH_W'(1);
    end

    // ------------------------------------------------------------------
    // Phase counter and turbo latch. Phase stays 0 on the first RUN cycle
    // and advances only while RUN persists; turbo is resampled only at the
    // end of a PSG period so the CPU strobe rate switches on a phase-0
    // boundary and no CPU period is cut short.
    // ------------------------------------------------------------------
    assign w_run_stay = (r_state == ST_RUN) && !w_abort;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= '0;
            r_turbo_q <= 1'b0;
        end else if (w_run_stay) begin
            r_phase <= r_phase + PHASE_W'(1);
            if (r_phase == PHASE_LAST)
                r_turbo_q <= turbo;
        end else begin
            r_phase   <= '0;
            r_turbo_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode. Dividers are powers of two, so "phase mod D"
    // is a mask with D-1, and the half-period point is that mask >> 1.
    // ------------------------------------------------------------------
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_cpu_mask  = r_turbo_q ? CPU_MASK_TRB : CPU_MASK_NRM;
        w_cpu_phase = r_phase & w_cpu_mask;

        sys_reset   = !w_run;
        sys_reset_n = w_run;
        ce_cpu      = w_run && (w_cpu_phase == w_cpu_mask);
        ce_cpu_n    = w_run && (w_cpu_phase == (w_cpu_mask >> 1));
        ce_fdc      = w_run && ((r_phase & FDC_MASK) == FDC_MASK);
        ce_psg      = w_run && (r_phase == PHASE_LAST);
        state       = r_state;
    end

endmodule

// File: tb/tb_einstein_clk_rst_gen.sv
// ----------------------------------------------------------------------------
// tb_einstein_clk_rst_gen
//
// Directed bench for einstein_clk_rst_gen with default parameters
// (STRETCH_CYCLES=1024, SYNC_STAGES=2, CPU_DIV=8, FDC_DIV=4, PSG_DIV=16).
// Inputs change on the falling edge of clk_sys; outputs are sampled there.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_einstein_clk_rst_gen;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       turbo;
    logic       sys_reset;
    logic       sys_reset_n;
    logic       ce_cpu;
    logic       ce_cpu_n;
    logic       ce_fdc;
    logic       ce_psg;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    einstein_clk_rst_gen #(
        .STRETCH_CYCLES (1024),
        .SYNC_STAGES    (2),
        .CPU_DIV        (8),
        .FDC_DIV        (4),
        .PSG_DIV        (16)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .soft_reset  (soft_reset),
        .turbo       (turbo),
        .sys_reset   (sys_reset),
        .sys_reset_n (sys_reset_n),
        .ce_cpu      (ce_cpu),
        .ce_cpu_n    (ce_cpu_n),
        .ce_fdc      (ce_fdc),
        .ce_psg      (ce_psg),
        .state       (state)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps falling edges until state==RUN. t_stretch is the step at which
    // the final STRETCH phase began; n_bad counts cycles outside RUN that
    // showed a strobe or a wrong reset level. -1 means "not reached".
    task automatic run_until_run(input int budget, output int t_stretch,
                                 output int t_run, output int n_bad);
        t_stretch = -1;
        t_run     = -1;
        n_bad     = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk_sys);
            if (state == 2'b00)
                t_stretch = -1;
            else if (state == 2'b01 && t_stretch < 0)
                t_stretch = n;
            if (state == 2'b10) begin
                t_run = n;
                break;
            end
            if ((ce_cpu | ce_cpu_n | ce_fdc | ce_psg) !== 1'b0 ||
                sys_reset !== 1'b1 || sys_reset_n !== 1'b0)
                n_bad++;
        end
    endtask

    // Samples n cycles starting at the current falling edge, building one
    // bit mask per strobe indexed by cycle. turbo rises at index turbo_at.
    task automatic capture(input int n, input int turbo_at,
                           output logic [63:0] m_cpu, output logic [63:0] m_cpun,
                           output logic [63:0] m_fdc, output logic [63:0] m_psg,
                           output int overlap);
        m_cpu = '0; m_cpun = '0; m_fdc = '0; m_psg = '0; overlap = 0;
        for (int i = 0; i < n; i++) begin
            if (ce_cpu === 1'b1)   m_cpu  |= (64'd1 << i);
            if (ce_cpu_n === 1'b1) m_cpun |= (64'd1 << i);
            if (ce_fdc === 1'b1)   m_fdc  |= (64'd1 << i);
            if (ce_psg === 1'b1)   m_psg  |= (64'd1 << i);
            if (ce_cpu === 1'b1 && ce_cpu_n === 1'b1) overlap++;
            if (i == turbo_at) turbo = 1'b1;
            @(negedge clk_sys);
        end
    endtask

    initial begin
        int t_s, t_r, bad, ovl, steps, last, min_gap;
        logic [63:0] mc, mn, mf, mp;

        // ---------------- Power-up ----------------
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        soft_reset = 1'b0;
        turbo      = 1'b0;
        #1;
        chk("rst_sys_reset",   sys_reset,   1'b1);
        chk("rst_sys_reset_n", sys_reset_n, 1'b0);
        chk("rst_state",       state,       2'b00);
        chk("rst_strobes",     {ce_cpu, ce_cpu_n, ce_fdc, ce_psg}, 4'b0000);
        repeat (5) @(negedge clk_sys);
        chk("rst_hold_strobes", {ce_cpu, ce_cpu_n, ce_fdc, ce_psg, sys_reset}, 5'b00001);
        reset_n = 1'b1;
        run_until_run(2000, t_s, t_r, bad);
        chk("pwr_stretch_edge", t_s, 3);
        chk("pwr_run_edge",     t_r, 1027);
        chk("pwr_bad_cycles",   bad, 0);
        chk("pwr_released",     {sys_reset, sys_reset_n}, 2'b01);

        // ---------------- Cadence, turbo=0, 64 cycles ----------------
        capture(64, -1, mc, mn, mf, mp, ovl);
        chk("cad_cpu",     mc, 64'h8080808080808080);
        chk("cad_cpu_n",   mn, 64'h0808080808080808);
        chk("cad_fdc",     mf, 64'h8888888888888888);
        chk("cad_psg",     mp, 64'h8000800080008000);
        chk("cad_overlap", ovl, 0);

        // ---------------- Turbo raised at PSG-relative index 5 --------
        capture(32, 5, mc, mn, mf, mp, ovl);
        chk("trb_cpu",     mc[31:0], 32'h88888080);
        chk("trb_cpu_n",   mn[31:0], 32'h22220808);
        chk("trb_fdc",     mf[31:0], 32'h88888888);
        chk("trb_psg",     mp[31:0], 32'h80008000);
        chk("trb_overlap", ovl, 0);
        last = -100; min_gap = 100;
        for (int i = 0; i < 32; i++) begin
            if (mc[i]) begin
                if (i - last < min_gap) min_gap = i - last;
                last = i;
            end
        end
        chk("trb_min_gap_ok", (min_gap >= 4), 1'b1);

        // ---------------- Soft reset at RUN index 100 ----------------
        repeat (4) @(negedge clk_sys);
        chk("sft_pre_state", state, 2'b10);
        soft_reset = 1'b1;
        @(negedge clk_sys);
        soft_reset = 1'b0;
        chk("sft_sys_reset", {sys_reset, sys_reset_n}, 2'b10);
        chk("sft_state",     state, 2'b00);
        chk("sft_strobes",   {ce_cpu, ce_cpu_n, ce_fdc, ce_psg}, 4'b0000);
        run_until_run(2000, t_s, t_r, bad);
        chk("sft_stretch_edge", t_s, 1);
        chk("sft_run_edge",     t_r, 1025);
        chk("sft_bad_cycles",   bad, 0);

        // First strobes after re-entry: turbo is still 1 at the pin, but the
        // latched mode restarts in normal rate until the first PSG boundary.
        capture(16, -1, mc, mn, mf, mp, ovl);
        chk("first_cpu",   mc[15:0], 16'h8080);
        chk("first_cpu_n", mn[15:0], 16'h0808);
        chk("first_fdc",   mf[15:0], 16'h8888);
        chk("first_psg",   mp[15:0], 16'h8000);
        turbo = 1'b0;

        // ---------------- Lock loss mid-RUN ----------------
        pll_locked = 1'b0;
        steps = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_sys);
            if (sys_reset === 1'b1) begin
                steps = n;
                break;
            end
        end
        chk("lock_loss_edges",   steps, 3);
        chk("lock_loss_strobes", {ce_cpu, ce_cpu_n, ce_fdc, ce_psg}, 4'b0000);

        pll_locked = 1'b1;
        steps = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_sys);
            if (state == 2'b01) begin
                steps = n;
                break;
            end
        end
        chk("lock_back_stretch", steps, 3);
        repeat (500) @(negedge clk_sys);
        chk("lock_mid_stretch", state, 2'b01);
        // One-cycle lock drop at stretch count 500 must restart the stretch.
        pll_locked = 1'b0;
        @(negedge clk_sys);
        pll_locked = 1'b1;
        run_until_run(2000, t_s, t_r, bad);
        chk("glitch_stretch_edge", t_s, 3);
        chk("glitch_run_edge",     t_r, 1027);
        chk("glitch_bad_cycles",   bad, 0);

        // ---------------- Async reset mid-STRETCH ----------------
        soft_reset = 1'b1;
        @(negedge clk_sys);
        soft_reset = 1'b0;
        repeat (300) @(negedge clk_sys);
        chk("arst_pre_state", state, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sys_reset", {sys_reset, sys_reset_n}, 2'b10);
        chk("arst_state",     state, 2'b00);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        run_until_run(2000, t_s, t_r, bad);
        chk("arst_stretch_edge", t_s, 3);
        chk("arst_run_edge",     t_r, 1027);
        chk("arst_bad_cycles",   bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
